// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
package multdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } md_state_t;

  localparam int MUL_EXC_CODE = 4;
  localparam int DIV_EXC_CODE = 5;
  localparam int RSTATUS_REG  = 30;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/multdiv_issue_if.sv
// Issue, multdiv-unit and writeback signals of the multdiv issue controller.
interface multdiv_issue_if;
  logic        issue_valid;
  logic        issue_op;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic        flush;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        wb_ready;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_exception;

  // Pipeline / multdiv-unit side: drives instructions and unit responses.
  modport master (
    output issue_valid, issue_op, issue_a, issue_b, issue_rd, flush,
           md_result, md_exception, md_resultRDY, wb_ready,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
           stall, busy, wb_valid, wb_data, wb_rd, wb_exception
  );

  // Issue controller side.
  modport slave (
    input  issue_valid, issue_op, issue_a, issue_b, issue_rd, flush,
           md_result, md_exception, md_resultRDY, wb_ready,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
           stall, busy, wb_valid, wb_data, wb_rd, wb_exception
  );
endinterface

// File: rtl/multdiv_issue_md_timeout_ctr.sv
// Saturating WAIT/DRAIN cycle counter; hit is high once the count equals MAX.
module md_timeout_ctr #(
  parameter int MAX = 48
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  assign o_hit = (r_cnt == W'(MAX));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_hit) begin
      r_cnt <= r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/multdiv_issue.sv
// Issue controller between X stage and the shared multdiv unit: latches operands,
// strobes the unit once, stalls the pipe until the result (or timeout) reaches writeback.
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT      = 48,
  parameter int RSTATUS_REG  = multdiv_pkg::RSTATUS_REG,
  parameter int MUL_EXC_CODE = multdiv_pkg::MUL_EXC_CODE,
  parameter int DIV_EXC_CODE = multdiv_pkg::DIV_EXC_CODE
) (
  input logic            clock,
  input logic            reset_n,
  multdiv_issue_if.slave bus
);
  md_state_t   r_state;
  md_state_t   w_next;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_res;
  logic        r_exc;
  logic        r_mult;
  logic        r_div;
  logic        w_hit;
  logic        w_accept;
  logic        w_capture;
  logic        w_done;
  logic        w_stall;

  md_timeout_ctr #(.MAX(TIMEOUT)) u_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clr   (r_state == S_START),
    .i_en    ((r_state == S_WAIT) || (r_state == S_DRAIN)),
    .o_hit   (w_hit)
  );

  assign w_accept  = (r_state == S_IDLE) && bus.issue_valid;
  assign w_capture = (r_state == S_WAIT) && !bus.flush && (bus.md_resultRDY || w_hit);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.issue_valid) w_next = S_START;
      // resultRDY is not looked at in START: it may be left over from the last op.
      S_START: w_next = bus.flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (bus.flush)                          w_next = S_DRAIN;
        else if (bus.md_resultRDY || w_hit)     w_next = S_DONE;
      end
      S_DONE:  if (bus.flush || bus.wb_ready) w_next = S_IDLE;
      S_DRAIN: if (bus.md_resultRDY || w_hit) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_op    <= OP_MUL;
      r_rd    <= '0;
      r_res   <= '0;
      r_exc   <= 1'b0;
      r_mult  <= 1'b0;
      r_div   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mult  <= w_accept && (bus.issue_op == OP_MUL);
      r_div   <= w_accept && (bus.issue_op == OP_DIV);
      if (w_accept) begin
        r_opa <= bus.issue_a;
        r_opb <= bus.issue_b;
        r_op  <= bus.issue_op;
        r_rd  <= bus.issue_rd;
      end
      if (w_capture) begin
        r_res <= bus.md_resultRDY ? bus.md_result : '0;
        r_exc <= bus.md_resultRDY ? bus.md_exception : 1'b1;
      end
    end
  end

  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      S_IDLE:          w_stall = bus.issue_valid;
      S_START, S_WAIT: w_stall = 1'b1;
      S_DONE:          w_stall = !bus.wb_ready;
      S_DRAIN:         w_stall = bus.issue_valid;
      default:         w_stall = 1'b0;
    endcase
    if (bus.flush) w_stall = 1'b0;
  end

  // A flush in DONE suppresses the result in the same cycle it arrives.
  assign w_done = (r_state == S_DONE) && !bus.flush;

  assign bus.md_operandA  = r_opa;
  assign bus.md_operandB  = r_opb;
  assign bus.md_ctrl_MULT = r_mult;
  assign bus.md_ctrl_DIV  = r_div;
  assign bus.stall        = w_stall;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.wb_valid     = w_done;
  assign bus.wb_exception = w_done && r_exc;
  assign bus.wb_data      = !w_done ? 32'd0 :
                            !r_exc  ? r_res :
                            (r_op == OP_DIV) ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
  assign bus.wb_rd        = !w_done ? 5'd0 : (r_exc ? 5'(RSTATUS_REG) : r_rd);
endmodule

// File: doc/multdiv_issue.md
# multdiv_issue

Pipeline-side controller for the shared multiply/divide unit. It accepts one MULT or DIV from the execute stage and latches the operands. It fires a single-cycle start strobe into the multdiv unit, holds the pipeline stalled until `md_resultRDY`, and presents the result or exception to writeback. The block sits between the X stage and the multdiv unit, on the initiator side of the `ctrl_MULT`/`ctrl_DIV`/`data_resultRDY` handshake.

## Interface
Parameters:
- `TIMEOUT`, 48: maximum cycles in WAIT before a forced exception.
- `RSTATUS_REG`, 30: destination register for exception status.
- `MUL_EXC_CODE`, 4: status value written on multiply overflow.
- `DIV_EXC_CODE`, 5: status value written on divide exception or divide by zero.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: a MULT/DIV instruction is in X.
- `issue_op` in 1: 0 = multiply, 1 = divide.
- `issue_a`, `issue_b` in 32: source operands.
- `issue_rd` in 5: destination register.
- `flush` in 1: kill the in-flight operation (branch or jump squash).
- `md_result` in 32, `md_exception` in 1, `md_resultRDY` in 1: from the multdiv unit.
- `wb_ready` in 1: writeback accepts the result this cycle.
- `md_operandA`, `md_operandB` out 32: registered operands, stable from START until the next accept.
- `md_ctrl_MULT`, `md_ctrl_DIV` out 1: start strobes, one cycle wide, registered.
- `stall` out 1: freeze F/D/X.
- `busy` out 1: state is not IDLE.
- `wb_valid` out 1, `wb_data` out 32, `wb_rd` out 5, `wb_exception` out 1: result to writeback.

## Operation
- States: IDLE, START, WAIT, DONE, DRAIN. Reset state is IDLE.
- Reset values: all outputs are 0, the operand registers are 0, and the timeout counter is 0.
- **IDLE**
  - If `issue_valid`, latch `issue_a`, `issue_b`, `issue_op` and `issue_rd`, then go to START.
  - `issue_valid` is not sampled again until the block returns to IDLE.
- **START**
  - Drive exactly one of `md_ctrl_MULT`/`md_ctrl_DIV` for this single cycle, selected by the latched op.
  - Clear the counter and go to WAIT.
  - `md_resultRDY` is ignored in START because it may be stale from the previous operation.
- **WAIT**
  - The counter increments every cycle.
  - On `md_resultRDY`, capture `md_result` and `md_exception`, then go to DONE.
  - If the counter reaches `TIMEOUT`, force an exception and go to DONE.
- **DONE**
  - Hold `wb_valid`=1.
  - Normal result: `wb_data`=`md_result`, `wb_rd`=latched rd, `wb_exception`=0.
  - Exception result: `wb_data` = `MUL_EXC_CODE` or `DIV_EXC_CODE` by op, `wb_rd`=`RSTATUS_REG`, `wb_exception`=1.
  - On `wb_ready`, go to IDLE.
- **Flush**
  - Flush in START or WAIT goes to DRAIN, because the multdiv unit cannot be aborted.
  - DRAIN waits for `md_resultRDY` or the timeout, discards the result, and returns to IDLE.
  - Flush in DONE drops the result and goes to IDLE.
  - Flush in IDLE or DRAIN has no effect.
  - Flush takes priority over `md_resultRDY` in the same cycle.
  - `wb_valid` is never asserted for a flushed operation.
- **stall** (combinational), asserted when any of the following holds:
  - state is IDLE and `issue_valid`;
  - state is START or WAIT;
  - state is DONE and `wb_ready` is low;
  - state is DRAIN and `issue_valid`.
  - `flush` forces `stall`=0.
- **Arithmetic and widths**
  - The block performs no arithmetic on data; it only selects and passes values through.
  - The counter is `$clog2(TIMEOUT+1)` bits and saturates.
  - The exception codes are zero-extended to 32 bits.

## Timing
- The accept edge is cycle 0. The strobe is high in cycle 1. The earliest `md_resultRDY` sample is cycle 2. `wb_valid` rises one cycle after `md_resultRDY` is sampled.
- Back-to-back operations have at least one IDLE cycle between DONE and the next START.
- Reset mid-operation returns the block to IDLE immediately and deasserts `stall` and `wb_valid` asynchronously.
- The multdiv unit may still be running after such a reset. The first START after reset re-arms the unit with a fresh strobe.
- `md_operandA`/`md_operandB` must not change between START and leaving WAIT or DRAIN.

## Structure
- A shared package `multdiv_pkg` holds:
  - the state enum;
  - `MUL_EXC_CODE`, `DIV_EXC_CODE` and `RSTATUS_REG` as defaults;
  - the op encoding constants `OP_MUL`=0 and `OP_DIV`=1.
- One natural sub-module, `md_timeout_ctr`: a saturating counter with clear and enable, and a `hit` output.

## Test plan
- Multiply 7 × 6, rd=5, `wb_ready`=1, unit returns RDY after 32 cycles:
  - one `md_ctrl_MULT` pulse;
  - `stall` high throughout the operation;
  - `wb_valid` for one cycle with `wb_data`=42, `wb_rd`=5, `wb_exception`=0.
- Divide 100 / 7, rd=9: one `md_ctrl_DIV` pulse, then `wb_data`=14 and `wb_rd`=9.
- Divide 5 / 0, unit raises `md_exception`: `wb_rd`=30, `wb_data`=5, `wb_exception`=1.
- Flush 3 cycles into WAIT with a new MULT issued immediately after:
  - no `wb_valid` for the flushed operation;
  - the new strobe fires only after the drained RDY;
  - the correct product is then written back.
- `md_resultRDY` held low with `TIMEOUT`=48, op=MUL: after 48 WAIT cycles, `wb_exception`=1, `wb_data`=4, `wb_rd`=30.
- `reset_n` pulsed low mid-WAIT, and `wb_ready` held low in DONE:
  - after reset, all outputs are 0 and the state is IDLE;
  - in DONE with `wb_ready` low, `wb_valid` and `stall` hold with stable data until `wb_ready` rises.
